seven_seg_driver: RTL

SEVEN_SEG_DRIVER -- requirements
Module: seven_seg_driver

---
 rtl/seven_seg_driver.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_driver.sv
// Four-digit multiplexed seven-segment driver: sequential double-dabble converts
// the 13-bit binary input to BCD, and a refresh scanner drives one digit at a time.
module seven_seg_driver #(
    parameter int REFRESH_CYCLES = 100000,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [15:0] bcd,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int            CW          = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] REFRESH_MAX = CW'(REFRESH_CYCLES - 1);

    state_t        state, state_nxt;
    logic [12:0]   shown;
    logic [12:0]   latched;
    logic [12:0]   shreg;
    logic [15:0]   scratch;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] refresh_cnt;
    logic [1:0]    idx;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    seg_nxt;

    function automatic logic [15:0] add3(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: default assignment first keeps this combinational and avoids an inferred latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (value != shown) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == 4'd12) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Conversion datapath; bcd only changes in DONE, so an aborted run leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shown   <= '0;
            latched <= '0;
            shreg   <= '0;
            scratch <= '0;
            bit_cnt <= '0;
            bcd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (value != shown) begin
                        latched <= value;
                        shreg   <= value;
                        scratch <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    {scratch, shreg} <= {add3(scratch), shreg} << 1;
                    bit_cnt          <= bit_cnt + 4'd1;
                end
                DONE: begin
                    bcd   <= scratch;
                    shown <= latched;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == REFRESH_MAX) begin
            refresh_cnt <= '0;
            idx         <= idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // A digit blanks when it and every more-significant nibble are zero; digit 0 never blanks.
    always_comb begin
        nibble = bcd[{idx, 2'b00} +: 4];
        case (idx)
            2'd3:    blank = BLANK_LZ && (bcd[15:12] == 4'd0);
            2'd2:    blank = BLANK_LZ && (bcd[15:8]  == 8'd0);
            2'd1:    blank = BLANK_LZ && (bcd[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase
        seg_nxt = blank ? 7'b1111111 : decode(nibble);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= seg_nxt;
        end
    end

endmodule
